// File: rtl/modn_down_counter_pkg.sv
// Shared constants and helpers for the modulo-N down counter.
// Used by the top module and the bench.
package modn_counter_pkg;

    localparam int DEFAULT_MOD = 6;

    // Counter value on reset and the value it wraps to, for the default MOD=6 build.
    localparam logic [2:0] MOD6_RESET_VAL = 3'd0;
    localparam logic [2:0] MOD6_WRAP_VAL  = 3'd5;

    // Like $clog2, but never returns 0, so a counter is always at least 1 bit wide.
    function automatic int clog2_min1(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/modn_down_counter_if.sv
// Command and status bundle for the modulo-N down counter.
// The load/load_val fields exist only when MODN_DOWN_LOAD_EN is defined.
interface modn_down_counter_if #(
    parameter int W = 3
);
    logic         en;
`ifdef MODN_DOWN_LOAD_EN
    logic         load;
    logic [W-1:0] load_val;
`endif
    logic [W-1:0] count;
    logic         zero;
    logic         borrow;

`ifdef MODN_DOWN_LOAD_EN
    modport master (output en, load, load_val, input count, zero, borrow);
    modport slave  (input en, load, load_val, output count, zero, borrow);
`else
    modport master (output en, input count, zero, borrow);
    modport slave  (input en, output count, zero, borrow);
`endif
endinterface

// File: rtl/modn_down_counter_dff_sr.sv
// Single-bit D flip-flop with a synchronous active-high reset.
// The counter uses one of these for each bit.
module dff_sr #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic srst,
    input  logic d,
    output logic q
);
    always_ff @(posedge clk) begin
        if (srst) q <= RST_VAL;
        else      q <= d;
    end
endmodule

// File: rtl/modn_down_counter.sv
// Modulo-N down counter with a borrow output for cascading.
// The optional parallel load is enabled by defining MODN_DOWN_LOAD_EN.
module modn_down_counter
    import modn_counter_pkg::*;
#(
    parameter int MOD = DEFAULT_MOD,
    parameter int W   = clog2_min1(MOD)
) (
    input logic               clk,
    input logic               rst,
    modn_down_counter_if.slave bus
);
    localparam logic [W-1:0] WRAP_VAL = W'(MOD - 1);

    logic [W-1:0] q;
    logic [W-1:0] d;
    logic [W-1:0] dec;
    logic [W-1:0] dec_safe;
    logic [W-1:0] ld_sat;
    logic         take_load;
    logic         take_en;
    logic         illegal;
    logic         zero;

`ifdef MODN_DOWN_LOAD_EN
    assign take_load = bus.load;
    // Out-of-range load values clamp to the top count.
    assign ld_sat    = (int'(bus.load_val) < MOD) ? bus.load_val : WRAP_VAL;
`else
    assign take_load = 1'b0;
    assign ld_sat    = '0;
`endif

    assign take_en = bus.en & ~take_load;

    generate
        if (MOD == 6) begin : g_mod6
            // Hand-reduced decrement: 0->5, 5->4, ..., 1->0.
            assign dec[0] = ~q[0];
            assign dec[1] = (q[1] & q[0]) | (q[2] & ~q[1] & ~q[0]);
            assign dec[2] = (q[2] & q[0]) | (~q[2] & ~q[1] & ~q[0]);
        end else begin : g_generic
            assign dec = (q == '0) ? WRAP_VAL : q - W'(1);
        end
    endgenerate

    // States at or above MOD are recovered to the top count on the next enabled edge.
    assign illegal  = int'(q) >= MOD;
    assign dec_safe = illegal ? WRAP_VAL : dec;

    generate
        for (genvar gi = 0; gi < W; gi++) begin : g_bit
            assign d[gi] = take_load ? ld_sat[gi] :
                           take_en   ? dec_safe[gi] : q[gi];

            dff_sr #(.RST_VAL(1'b0)) u_ff (
                .clk  (clk),
                .srst (rst),
                .d    (d[gi]),
                .q    (q[gi])
            );
        end
    endgenerate

    assign zero       = (q == '0);
    assign bus.count  = q;
    assign bus.zero   = zero;
    assign bus.borrow = bus.en & ~take_load & zero & ~rst;

endmodule

// File: tb/tb_modn_down_counter.sv
// Directed bench for modn_down_counter: wrap sequence, enable gaps, load, reset, cascade.
// Load scenarios run only when MODN_DOWN_LOAD_EN is defined.
module tb_modn_down_counter;
    import modn_counter_pkg::*;

    localparam int MOD = 6;
    localparam int W   = 3;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    modn_down_counter_if #(.W(W)) bus ();
    modn_down_counter_if #(.W(W)) lo_bus ();
    modn_down_counter_if #(.W(W)) hi_bus ();

    modn_down_counter #(.MOD(MOD), .W(W)) dut  (.clk(clk), .rst(rst), .bus(bus));
    modn_down_counter #(.MOD(MOD), .W(W)) u_lo (.clk(clk), .rst(rst), .bus(lo_bus));
    modn_down_counter #(.MOD(MOD), .W(W)) u_hi (.clk(clk), .rst(rst), .bus(hi_bus));

    assign hi_bus.en = lo_bus.borrow;
`ifdef MODN_DOWN_LOAD_EN
    assign lo_bus.load     = 1'b0;
    assign lo_bus.load_val = '0;
    assign hi_bus.load     = 1'b0;
    assign hi_bus.load_val = '0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.en = 1'b0;
        lo_bus.en = 1'b0;
`ifdef MODN_DOWN_LOAD_EN
        bus.load = 1'b0;
        bus.load_val = '0;
`endif
        tick();
        tick();
        total++; if (bus.count !== MOD6_RESET_VAL) begin bad++; $display("FAIL reset_count got=%0d exp=%0d", bus.count, MOD6_RESET_VAL); end
        total++; if (bus.zero !== 1'b1) begin bad++; $display("FAIL reset_zero got=%b exp=1", bus.zero); end
        total++; if (bus.borrow !== 1'b0) begin bad++; $display("FAIL reset_borrow got=%b exp=0", bus.borrow); end
        bus.en = 1'b1;
        #1;
        total++; if (bus.borrow !== 1'b0) begin bad++; $display("FAIL reset_borrow_en got=%b exp=0", bus.borrow); end
        bus.en = 1'b0;
        tick();
        rst = 1'b0;
        $display("reset: count=%0d zero=%b", bus.count, bus.zero);
    endtask

    task automatic test_wrap();
        logic [W-1:0] seq [8];
        seq = '{3'd0, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, MOD6_WRAP_VAL};
        for (int i = 0; i < 8; i++) begin
            bus.en = 1'b1;
            #1;
            total++; if (bus.count !== seq[i]) begin bad++; $display("FAIL wrap_count[%0d] got=%0d exp=%0d", i, bus.count, seq[i]); end
            total++; if (bus.borrow !== (seq[i] == 3'd0)) begin bad++; $display("FAIL wrap_borrow[%0d] got=%b exp=%b", i, bus.borrow, seq[i] == 3'd0); end
            total++; if (bus.zero !== (seq[i] == 3'd0)) begin bad++; $display("FAIL wrap_zero[%0d] got=%b exp=%b", i, bus.zero, seq[i] == 3'd0); end
            $display("wrap cycle %0d: count=%0d borrow=%b", i, bus.count, bus.borrow);
            tick();
        end
        bus.en = 1'b0;
    endtask

    task automatic test_enable_gap();
        logic         pat [4];
        logic [W-1:0] exp [4];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        exp = '{3'd2, 3'd2, 3'd2, 3'd1};
        // Count is 4 after the wrap test; one enabled edge brings it to 3.
        bus.en = 1'b1;
        tick();
        total++; if (bus.count !== 3'd3) begin bad++; $display("FAIL gap_start got=%0d exp=3", bus.count); end
        for (int i = 0; i < 4; i++) begin
            bus.en = pat[i];
            #1;
            total++; if (bus.zero !== 1'b0) begin bad++; $display("FAIL gap_zero[%0d] got=%b exp=0", i, bus.zero); end
            total++; if (bus.borrow !== 1'b0) begin bad++; $display("FAIL gap_borrow[%0d] got=%b exp=0", i, bus.borrow); end
            tick();
            total++; if (bus.count !== exp[i]) begin bad++; $display("FAIL gap_count[%0d] got=%0d exp=%0d", i, bus.count, exp[i]); end
            $display("gap en=%b: count=%0d", pat[i], bus.count);
        end
        bus.en = 1'b0;
    endtask

`ifdef MODN_DOWN_LOAD_EN
    task automatic test_load();
        bus.en = 1'b1;
        bus.load = 1'b1;
        bus.load_val = 3'd4;
        #1;
        total++; if (bus.borrow !== 1'b0) begin bad++; $display("FAIL load4_borrow got=%b exp=0", bus.borrow); end
        tick();
        total++; if (bus.count !== 3'd4) begin bad++; $display("FAIL load4_count got=%0d exp=4", bus.count); end
        $display("load val=4: count=%0d", bus.count);
        bus.load_val = 3'd7;
        tick();
        total++; if (bus.count !== 3'd5) begin bad++; $display("FAIL load7_clamp got=%0d exp=5", bus.count); end
        $display("load val=7: count=%0d", bus.count);
        bus.load_val = 3'd0;
        tick();
        total++; if (bus.count !== 3'd0) begin bad++; $display("FAIL load0_count got=%0d exp=0", bus.count); end
        // At count 0 with en high, a pending load must suppress borrow.
        bus.load_val = 3'd3;
        #1;
        total++; if (bus.borrow !== 1'b0) begin bad++; $display("FAIL load_at_zero_borrow got=%b exp=0", bus.borrow); end
        tick();
        total++; if (bus.count !== 3'd3) begin bad++; $display("FAIL load3_count got=%0d exp=3", bus.count); end
        $display("load val=3 at zero: count=%0d", bus.count);
        bus.load = 1'b0;
        bus.en = 1'b0;
    endtask
`endif

    task automatic test_reset_midcount();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.en = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        total++; if (bus.count !== 3'd2) begin bad++; $display("FAIL mid_pre got=%0d exp=2", bus.count); end
        rst = 1'b1;
`ifdef MODN_DOWN_LOAD_EN
        bus.load = 1'b1;
        bus.load_val = 3'd4;
`endif
        tick();
        total++; if (bus.count !== 3'd0) begin bad++; $display("FAIL mid_rst_count got=%0d exp=0", bus.count); end
        total++; if (bus.zero !== 1'b1) begin bad++; $display("FAIL mid_rst_zero got=%b exp=1", bus.zero); end
`ifdef MODN_DOWN_LOAD_EN
        bus.load = 1'b0;
`endif
        #1;
        // en=1, load=0, count=0: only rst keeps borrow low here.
        total++; if (bus.borrow !== 1'b0) begin bad++; $display("FAIL mid_rst_borrow got=%b exp=0", bus.borrow); end
        $display("reset mid-count: count=%0d zero=%b borrow=%b", bus.count, bus.zero, bus.borrow);
        bus.en = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_cascade();
        int lo_m;
        int hi_m;
        int pulses;
        logic lo_b;
        rst = 1'b1;
        lo_bus.en = 1'b0;
        tick();
        rst = 1'b0;
        lo_m = 0;
        hi_m = 0;
        pulses = 0;
        lo_bus.en = 1'b1;
        for (int i = 0; i < 36; i++) begin
            #1;
            if (hi_bus.borrow === 1'b1) pulses++;
            tick();
            lo_b = (lo_m == 0);
            lo_m = lo_b ? MOD - 1 : lo_m - 1;
            if (lo_b) hi_m = (hi_m == 0) ? MOD - 1 : hi_m - 1;
            if ((i % 6) == 5) begin
                total++; if (int'(hi_bus.count) != hi_m || int'(lo_bus.count) != lo_m) begin
                    bad++; $display("FAIL cascade_step[%0d] got=%0d:%0d exp=%0d:%0d", i + 1, hi_bus.count, lo_bus.count, hi_m, lo_m);
                end
                $display("cascade edge %0d: hi=%0d lo=%0d", i + 1, hi_bus.count, lo_bus.count);
            end
        end
        total++; if (hi_bus.count !== 3'd0 || lo_bus.count !== 3'd0) begin bad++; $display("FAIL cascade_end got=%0d:%0d exp=0:0", hi_bus.count, lo_bus.count); end
        total++; if (pulses != 1) begin bad++; $display("FAIL cascade_hi_borrow pulses got=%0d exp=1", pulses); end
        lo_bus.en = 1'b0;
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst = 1'b1;
        #2;
        test_reset();
        test_wrap();
        test_enable_gap();
`ifdef MODN_DOWN_LOAD_EN
        test_load();
`endif
        test_reset_midcount();
        test_cascade();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
